// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg
//   Definitions shared by the serial subtractor files: the controller state
//   encoding, the default operand width and the bit-counter width helper.
package serial_sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Bits needed for a counter that can represent 0..w.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_one_bit_full_subtractor.sv
// one_bit_full_subtractor
//   Purely combinational single-bit subtractor: a - b - bin.
// Ports:
//   a, b  : operand bits
//   bin   : borrow in
//   diff  : difference bit
//   bout  : borrow out
module one_bit_full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor. One subtraction A - B - Bin is processed
//   LSB first, one bit per clock, through a single full-subtractor cell.
//   Result D = {borrow_out, difference} is loaded when the operation completes
//   and holds until the next completion or reset.
// Parameters:
//   WIDTH : operand width (2..16)
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset (priority over start)
//   start : request a subtraction; accepted in IDLE or DONE only
//   A, B  : minuend / subtrahend, captured on start acceptance
//   Bin   : borrow-in, captured on start acceptance
//   busy  : high while shifting (WIDTH cycles)
//   done  : one-cycle completion pulse
//   D     : {borrow_out, difference}
//   ovf   : two's-complement overflow flag, present only when the
//           SERIAL_SUB_OVF_EN macro is defined
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   D
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb;
  logic [WIDTH-2:0] res;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             diff, bout;
  logic             accept, last;
  logic [WIDTH-1:0] res_shift;

  one_bit_full_subtractor u_bit (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (br),
    .diff (diff),
    .bout (bout)
  );

  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign last      = (cnt == CW'(WIDTH - 1));
  // Result register keeps only WIDTH-1 bits; the final diff bit is merged
  // straight into D on the last shift so no cycle is spent on a final shift.
  assign res_shift = {diff, res};

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      cnt   <= '0;
      br    <= 1'b0;
      D     <= '0;
`ifdef SERIAL_SUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        sa  <= A;
        sb  <= B;
        br  <= Bin;
        cnt <= '0;
      end else if (state == SHIFT) begin
        sa  <= sa >> 1;
        sb  <= sb >> 1;
        br  <= bout;
        res <= res_shift[WIDTH-1:1];
        cnt <= cnt + CW'(1);
        if (last) begin
          D <= {bout, res_shift};
`ifdef SERIAL_SUB_OVF_EN
          // On the last shift sa[0]/sb[0] are the original operand MSBs.
          ovf <= (sa[0] ^ sb[0]) & (diff ^ sa[0]);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A, B;
  logic         Bin;
  logic         busy, done;
  logic [W:0]   D;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
  logic         ovf_q[$];
`endif

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [W:0]  exp_q[$];
  logic [W:0]  last_d;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .D     (D)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic bin);
    return {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
  endfunction

`ifdef SERIAL_SUB_OVF_EN
  function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic bin);
    int r;
    r = $signed({{(32-W){a[W-1]}}, a}) - $signed({{(32-W){b[W-1]}}, b}) - int'(bin);
    return (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
  endfunction
`endif

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    A = a; B = b; Bin = bin; start = 1'b1;
    exp_q.push_back(model(a, b, bin));
`ifdef SERIAL_SUB_OVF_EN
    ovf_q.push_back(model_ovf(a, b, bin));
`endif
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered at the first sample after acceptance; returns in the DONE cycle.
  task automatic expect_op(input string name);
    logic [W:0] exp_d;
    for (int unsigned k = 1; k <= W; k++) begin
      checks++;
      if ({busy, done} !== 2'b10) begin
        failures++;
        $display("FAIL %s busy/done cycle %0d: got %b expected 10", name, k, {busy, done});
      end
      checks++;
      if (D !== last_d) begin
        failures++;
        $display("FAIL %s D hold cycle %0d: got %b expected %b", name, k, D, last_d);
      end
      @(negedge clk);
    end
    checks++;
    if ({busy, done} !== 2'b01) begin
      failures++;
      $display("FAIL %s done cycle: got busy/done %b expected 01", name, {busy, done});
    end
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard: got empty queue expected an entry", name);
    end else begin
      exp_d = exp_q.pop_front();
      if (D !== exp_d) begin
        failures++;
        $display("FAIL %s D: got %b expected %b", name, D, exp_d);
      end
      last_d = exp_d;
    end
`ifdef SERIAL_SUB_OVF_EN
    if (ovf_q.size() != 0) begin
      logic eo;
      eo = ovf_q.pop_front();
      checks++;
      if (ovf !== eo) begin
        failures++;
        $display("FAIL %s ovf: got %b expected %b", name, ovf, eo);
      end
    end
`endif
  endtask

  task automatic expect_idle(input string name);
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00 || D !== last_d) begin
      failures++;
      $display("FAIL %s idle: got busy/done %b D %b expected 00 D %b",
               name, {busy, done}, D, last_d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; A = 4'd9; B = 4'd3; Bin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; start = 1'b0;
    last_d = '0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset busy: got %b expected 0", busy); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset done: got %b expected 0", done); end
    checks++;
    if (D !== '0) begin failures++; $display("FAIL reset D: got %b expected 0", D); end
    expect_idle("reset_hold");
  endtask

  task automatic test_basic();
    drive_start(4'd9, 4'd3, 1'b0);
    expect_op("9-3");
    checks++;
    if (D !== 5'b0_0110) begin failures++; $display("FAIL 9-3 const: got %b expected 00110", D); end
    expect_idle("9-3_after");
    drive_start(4'd3, 4'd9, 1'b0);
    expect_op("3-9");
    checks++;
    if (D !== 5'b1_1010) begin failures++; $display("FAIL 3-9 const: got %b expected 11010", D); end
    expect_idle("3-9_after");
  endtask

  task automatic test_back_to_back();
    drive_start(4'd0, 4'd0, 1'b1);
    expect_op("0-0-1");
    checks++;
    if (D !== 5'b1_1111) begin failures++; $display("FAIL 0-0-1 const: got %b expected 11111", D); end
    drive_start(4'd15, 4'd1, 1'b0);
    expect_op("15-1_b2b");
    checks++;
    if (D !== 5'b0_1110) begin failures++; $display("FAIL 15-1 const: got %b expected 01110", D); end
    expect_idle("b2b_after");
  endtask

  task automatic test_ignore_start();
    drive_start(4'd9, 4'd3, 1'b0);
    for (int unsigned k = 1; k <= W; k++) begin
      if (k == 2) begin start = 1'b1; A = 4'd1; B = 4'd1; Bin = 1'b0; end
      else start = 1'b0;
      checks++;
      if ({busy, done} !== 2'b10) begin
        failures++;
        $display("FAIL ignore busy cycle %0d: got %b expected 10", k, {busy, done});
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if ({done, D} !== {1'b1, 5'b0_0110}) begin
      failures++;
      $display("FAIL ignore done/D: got %b/%b expected 1/00110", done, D);
    end
    void'(exp_q.pop_front());
`ifdef SERIAL_SUB_OVF_EN
    void'(ovf_q.pop_front());
`endif
    last_d = 5'b0_0110;
    expect_idle("ignore_single_done");
  endtask

  task automatic test_reset_mid();
    drive_start(4'd9, 4'd3, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
`ifdef SERIAL_SUB_OVF_EN
    ovf_q.delete();
`endif
    last_d = '0;
    for (int unsigned k = 0; k < W + 2; k++) begin
      checks++;
      if ({busy, done} !== 2'b00 || D !== '0) begin
        failures++;
        $display("FAIL abort cycle %0d: got busy/done %b D %b expected 00 D 00000",
                 k, {busy, done}, D);
      end
      @(negedge clk);
    end
    drive_start(4'd6, 4'd2, 1'b0);
    expect_op("6-2_after_rst");
    checks++;
    if (D !== 5'b0_0100) begin failures++; $display("FAIL 6-2 const: got %b expected 00100", D); end
    expect_idle("6-2_after");
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      drive_start(W'($urandom), W'($urandom), 1'($urandom));
      expect_op("random");
      if (i % 3 == 2) expect_idle("random_gap");
    end
    expect_idle("random_end");
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    drive_start(4'b0111, 4'b1000, 1'b0);
    expect_op("ovf_7-8");
    checks++;
    if ({D, ovf} !== {5'b1_1111, 1'b1}) begin
      failures++;
      $display("FAIL ovf_7-8 const: got %b/%b expected 11111/1", D, ovf);
    end
    drive_start(4'd5, 4'd2, 1'b0);
    expect_op("ovf_5-2");
    checks++;
    if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_5-2 const: got %b expected 0", ovf); end
    expect_idle("ovf_after");
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0; last_d = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
